dp_fifo_arbiter: RTL and testbench
==================================

Name: dp_fifo_arbiter

Overview:
- Shares the DP↔VPI two-FIFO pipe between NUM_PORTS datapath requesters.
- Request side: round-robin arbitration; the winner is tagged with a TID and written into the request FIFO (DP→VPI).
- Response side: an FSM pops the serve FIFO (VPI→DP), decodes the TID and returns the data to the owning port.
- Per-port outstanding-credit counters keep each port's in-flight count at or below MAX_OUTSTANDING.

Parameters:
- DATA_WIDTH, 32, data field width.
- ADDR_WIDTH, 31, address field width.
- REQ_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH, request word {flag, addr, data}.
- TID_WIDTH, 16, transaction ID width.
- NUM_PORTS, 4, requester count (power of 2, ≥2).
- PORT_BITS, 2, log2(NUM_PORTS); TID[TID_WIDTH-1 -: PORT_BITS] = port index.
- MAX_OUTSTANDING, 8, in-flight limit per port.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_data  in  NUM_PORTS*REQ_WIDTH  flattened requests; port i at [i*REQ_WIDTH +: REQ_WIDTH].
- req_ready  out  NUM_PORTS  one-hot grant; the request is accepted this cycle.
- reqf_wr_data  out  TID_WIDTH+REQ_WIDTH  {TID, request} to the request FIFO.
- reqf_wr_en  out  1  request FIFO write.
- reqf_full  in  1  request FIFO full.
- srvf_rd_data  in  TID_WIDTH+DATA_WIDTH  {TID, data} from the serve FIFO; valid the cycle after rd_en.
- srvf_rd_en  out  1  serve FIFO read.
- srvf_empty  in  1  serve FIFO empty.
- resp_valid  out  NUM_PORTS  one-hot response valid.
- resp_data  out  DATA_WIDTH  response data, shared by all ports.
- resp_seq  out  TID_WIDTH-PORT_BITS  sequence field of the returned TID.
- resp_ready  in  NUM_PORTS  per-port response accept.
- err_tid  out  1  one-cycle pulse: response for a port with 0 outstanding.
- outstanding  out  NUM_PORTS*4  per-port in-flight counts, for debug.

Behaviour:
- Reset: all outputs are 0. rr_ptr=0, every seq counter=0, every outstanding counter=0, response FSM=IDLE. rst overrides everything in the same edge; in-flight FIFO entries are not flushed, which is the system's responsibility.

Request path (combinational grant, zero latency):
- A port is eligible when req_valid[i]=1 and outstanding[i]<MAX_OUTSTANDING.
- If reqf_full=1, nothing is granted.
- Otherwise grant the first eligible port searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
- On a grant:
  - req_ready[g]=1 and reqf_wr_en=1.
  - reqf_wr_data = {g, seq[g], req_data[g]}.
  - At the clock edge: seq[g]++ (wraps at 2^(TID_WIDTH-PORT_BITS)) and rr_ptr <= g+1 (mod NUM_PORTS).
- With no grant, rr_ptr holds. At most one write per cycle.

Response FSM:
- IDLE: if !srvf_empty, assert srvf_rd_en for one cycle and go to FETCH.
- FETCH: capture srvf_rd_data into the holding register and go to PRESENT.
- PRESENT:
  - resp_valid[p]=1 with p = captured TID port field; resp_data and resp_seq come from the holding register and stay stable while waiting.
  - When resp_ready[p]=1: retire, go to IDLE. The next pop starts in IDLE, so peak throughput is 1 response per 3 cycles.
- Backpressure: resp_valid holds indefinitely until resp_ready[p]=1; other ports' ready are ignored.

Outstanding counters:
- +1 on a grant to port i.
- −1 on a retire for port i.
- Grant and retire on the same port in the same cycle: unchanged.
- Retire with count=0: count stays 0, response is still delivered, err_tid pulses that cycle.

Boundaries:
- reqf_full asserted mid-stream: no grant that cycle; rr_ptr unchanged.
- A port at MAX_OUTSTANDING is skipped; the others proceed.
- Sequence wrap 0x3FFF→0x0000 for 14-bit seq.

Test Plan:
1. Reset, then ports 0..3 all valid continuously with reqf_full=0 → grants 0,1,2,3,0,… one per cycle; port 1's second write has TID 0x4001.
2. Only port 2 valid, no responses returned → 8 writes (TIDs 0x8000–0x8007), then req_ready[2] stays 0; outstanding[2]=8.
3. reqf_full=1 for 3 cycles during case 1 → reqf_wr_en=0 those cycles; arbitration resumes at the same rr_ptr.
4. Serve FIFO returns {0xC005, 0xDEADBEEF}, resp_ready[3]=0 for 4 cycles → resp_valid=4'b1000 with data stable; after ready, outstanding[3] decrements and FSM returns to IDLE.
5. Response TID 0x4000 while outstanding[1]=0 → resp_valid[1] pulses, err_tid=1 for one cycle, count stays 0.
6. rst asserted in PRESENT → next cycle resp_valid=0, FSM=IDLE, counters=0.

Source files
------------

// File: rtl/dp_fifo_arbiter_if.sv
// Handshake and FIFO bundle between NUM_PORTS datapath requesters,
// the DP->VPI request FIFO and the VPI->DP serve FIFO.
interface dp_fifo_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 31,
  parameter int REQ_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int TID_WIDTH  = 16,
  parameter int NUM_PORTS  = 4,
  parameter int PORT_BITS  = 2
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*REQ_WIDTH-1:0]  req_data;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [TID_WIDTH+REQ_WIDTH-1:0]  reqf_wr_data;
  logic                            reqf_wr_en;
  logic                            reqf_full;
  logic [TID_WIDTH+DATA_WIDTH-1:0] srvf_rd_data;
  logic                            srvf_rd_en;
  logic                            srvf_empty;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]           resp_data;
  logic [TID_WIDTH-PORT_BITS-1:0]  resp_seq;
  logic [NUM_PORTS-1:0]            resp_ready;
  logic                            err_tid;
  logic [NUM_PORTS*4-1:0]          outstanding;

  modport master (
    output req_valid, req_data, reqf_full,
    output srvf_rd_data, srvf_empty, resp_ready,
    input  req_ready, reqf_wr_data, reqf_wr_en,
    input  srvf_rd_en, resp_valid, resp_data,
    input  resp_seq, err_tid, outstanding
  );

  modport slave (
    input  req_valid, req_data, reqf_full,
    input  srvf_rd_data, srvf_empty, resp_ready,
    output req_ready, reqf_wr_data, reqf_wr_en,
    output srvf_rd_en, resp_valid, resp_data,
    output resp_seq, err_tid, outstanding
  );
endinterface

// File: rtl/dp_fifo_arbiter.sv
// Round-robin request arbiter with TID tagging, response router FSM
// and per-port outstanding credit counters over a two-FIFO pipe.
module dp_fifo_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 31,
  parameter int REQ_WIDTH       = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int TID_WIDTH       = 16,
  parameter int NUM_PORTS       = 4,
  parameter int PORT_BITS       = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic             clk,
  input logic             rst,
  dp_fifo_arbiter_if.slave bus
);
  localparam int SEQ_W = TID_WIDTH - PORT_BITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  logic [PORT_BITS-1:0] rr_ptr;
  logic [PORT_BITS-1:0] gnt_idx;
  logic [PORT_BITS-1:0] idx;
  logic                 found;
  logic                 gnt;
  logic [NUM_PORTS-1:0] elig;
  logic [SEQ_W-1:0]     seq [NUM_PORTS];
  logic [3:0]           cnt [NUM_PORTS];

  logic [1:0]            state;
  logic [TID_WIDTH-1:0]  hold_tid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [PORT_BITS-1:0]  rsp_port;
  logic                  retire;

  // A port may compete only while it has credit left.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      elig[i] = bus.req_valid[i] &&
                (cnt[i] < 4'(MAX_OUTSTANDING));
  end

  // First eligible port at or after rr_ptr wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + PORT_BITS'(k);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt = found && !bus.reqf_full && !rst;

  // Drive the request FIFO write with the tagged winner.
  always_comb begin
    bus.req_ready    = '0;
    bus.reqf_wr_en   = gnt;
    bus.reqf_wr_data = '0;
    if (gnt) begin
      bus.req_ready[gnt_idx] = 1'b1;
      bus.reqf_wr_data = {gnt_idx, seq[gnt_idx],
        bus.req_data[int'(gnt_idx)*REQ_WIDTH +: REQ_WIDTH]};
    end
  end

  assign rsp_port = hold_tid[TID_WIDTH-1 -: PORT_BITS];
  assign retire   = (state == PRESENT) && bus.resp_ready[rsp_port];

  // Present the held response to its owning port.
  always_comb begin
    bus.resp_valid = '0;
    if (state == PRESENT)
      bus.resp_valid[rsp_port] = 1'b1;
    bus.resp_data  = hold_data;
    bus.resp_seq   = hold_tid[SEQ_W-1:0];
    bus.srvf_rd_en = (state == IDLE) && !bus.srvf_empty && !rst;
    bus.err_tid    = retire && (cnt[rsp_port] == 4'd0);
  end

  // Flatten the credit counters for debug visibility.
  always_comb begin
    bus.outstanding = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      bus.outstanding[i*4 +: 4] = cnt[i];
  end

  // Round-robin pointer and per-port sequence numbers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_PORTS; i++)
        seq[i] <= '0;
    end else if (gnt) begin
      rr_ptr       <= gnt_idx + 1'b1;
      seq[gnt_idx] <= seq[gnt_idx] + 1'b1;
    end
  end

  // Credits: +1 on grant, -1 on retire, saturating at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else begin
        if (gnt && gnt_idx == PORT_BITS'(i) &&
            !(retire && rsp_port == PORT_BITS'(i)))
          cnt[i] <= cnt[i] + 4'd1;
        else if (retire && rsp_port == PORT_BITS'(i) &&
                 cnt[i] != 4'd0 &&
                 !(gnt && gnt_idx == PORT_BITS'(i)))
          cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  // Pop, capture, then hold the response until its port accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_tid  <= '0;
      hold_data <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.srvf_rd_en) state <= FETCH;
        FETCH: begin
          hold_tid  <= bus.srvf_rd_data[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
          hold_data <= bus.srvf_rd_data[DATA_WIDTH-1:0];
          state     <= PRESENT;
        end
        PRESENT:
          if (retire) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dp_fifo_arbiter.sv
// Directed bench for dp_fifo_arbiter: arbitration order, TID tags,
// credit limits, FIFO backpressure and response routing.
module tb_dp_fifo_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [47:0] srv_mem [8];
  int          push_cnt = 0;
  int          pop_cnt = 0;

  dp_fifo_arbiter_if bus ();

  dp_fifo_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.srvf_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (bus.srvf_rd_en && push_cnt != pop_cnt) begin
      bus.srvf_rd_data <= srv_mem[pop_cnt % 8];
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [79:0] got,
                       input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] w);
    srv_mem[push_cnt % 8] = w;
    push_cnt = push_cnt + 1;
    #1;
  endtask

  function automatic logic [63:0] req_word(input int i);
    logic [30:0] a;
    logic [31:0] d;
    a = 31'(i + 1);
    d = 32'hA000_0000 + 32'(i);
    return {1'b1, a, d};
  endfunction

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.reqf_full = 1'b0;
    bus.resp_ready = '0;
    bus.srvf_rd_data = '0;
    for (int i = 0; i < 4; i++)
      bus.req_data[i*64 +: 64] = req_word(i);
    tick();
    tick();
    check("rst_ready", 80'(bus.req_ready), 80'h0);
    check("rst_wr_en", 80'(bus.reqf_wr_en), 80'h0);
    check("rst_resp_valid", 80'(bus.resp_valid), 80'h0);
    check("rst_outstanding", 80'(bus.outstanding), 80'h0);
    check("rst_err", 80'(bus.err_tid), 80'h0);
    check("rst_rd_en", 80'(bus.srvf_rd_en), 80'h0);

    rst = 1'b0;
    tick();

    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_ready_%0d", k),
            80'(bus.req_ready), 80'(4'b0001 << (k % 4)));
      check($sformatf("rr_tid_%0d", k),
            80'(bus.reqf_wr_data[79:64]),
            80'({2'(k % 4), 14'(k / 4)}));
      tick();
    end
    check("rr_payload_p2", 80'(bus.reqf_wr_data[63:0]), 80'(req_word(2)));

    bus.reqf_full = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("full_wr_en_%0d", k), 80'(bus.reqf_wr_en), 80'h0);
      check($sformatf("full_ready_%0d", k), 80'(bus.req_ready), 80'h0);
      tick();
    end
    bus.reqf_full = 1'b0;
    #1;
    check("resume_ready", 80'(bus.req_ready), 80'h4);
    check("resume_tid", 80'(bus.reqf_wr_data[79:64]), 80'h8001);
    tick();
    bus.req_valid = '0;
    #1;
    check("rr_outstanding", 80'(bus.outstanding), 80'h1222);

    rst = 1'b1;
    tick();
    check("rst2_outstanding", 80'(bus.outstanding), 80'h0);
    rst = 1'b0;
    tick();

    bus.req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("p2_ready_%0d", k), 80'(bus.req_ready), 80'h4);
      check($sformatf("p2_tid_%0d", k),
            80'(bus.reqf_wr_data[79:64]), 80'(16'h8000 + 16'(k)));
      tick();
    end
    check("p2_cap_ready", 80'(bus.req_ready), 80'h0);
    check("p2_cap_wr_en", 80'(bus.reqf_wr_en), 80'h0);
    check("p2_cap_cnt", 80'(bus.outstanding), 80'h0800);
    bus.req_valid = 4'b0101;
    #1;
    check("skip_full_ready", 80'(bus.req_ready), 80'h1);
    check("skip_full_tid", 80'(bus.reqf_wr_data[79:64]), 80'h0000);
    tick();
    bus.req_valid = 4'b1000;
    #1;
    check("p3_ready", 80'(bus.req_ready), 80'h8);
    check("p3_tid", 80'(bus.reqf_wr_data[79:64]), 80'hC000);
    tick();
    bus.req_valid = '0;
    #1;
    check("pre_rsp_cnt", 80'(bus.outstanding), 80'h1801);

    bus.resp_ready = 4'b0111;
    push({16'hC005, 32'hDEADBEEF});
    check("pop_rd_en", 80'(bus.srvf_rd_en), 80'h1);
    tick();
    check("fetch_rd_en", 80'(bus.srvf_rd_en), 80'h0);
    check("fetch_valid", 80'(bus.resp_valid), 80'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_valid_%0d", k), 80'(bus.resp_valid), 80'h8);
      check($sformatf("bp_data_%0d", k), 80'(bus.resp_data), 80'hDEADBEEF);
      check($sformatf("bp_seq_%0d", k), 80'(bus.resp_seq), 80'h5);
      tick();
    end
    bus.resp_ready = 4'b1000;
    #1;
    check("retire_err", 80'(bus.err_tid), 80'h0);
    tick();
    check("post_valid", 80'(bus.resp_valid), 80'h0);
    check("post_cnt", 80'(bus.outstanding), 80'h0801);

    bus.resp_ready = 4'b0010;
    push({16'h4000, 32'h12345678});
    tick();
    tick();
    check("err_valid", 80'(bus.resp_valid), 80'h2);
    check("err_data", 80'(bus.resp_data), 80'h12345678);
    check("err_pulse", 80'(bus.err_tid), 80'h1);
    tick();
    check("err_clear", 80'(bus.err_tid), 80'h0);
    check("err_valid_off", 80'(bus.resp_valid), 80'h0);
    check("err_cnt", 80'(bus.outstanding), 80'h0801);

    bus.resp_ready = '0;
    push({16'h8003, 32'hCAFEF00D});
    tick();
    tick();
    check("rst_pres_valid", 80'(bus.resp_valid), 80'h4);
    rst = 1'b1;
    tick();
    check("rst_pres_valid_off", 80'(bus.resp_valid), 80'h0);
    check("rst_pres_cnt", 80'(bus.outstanding), 80'h0);
    check("rst_pres_err", 80'(bus.err_tid), 80'h0);
    rst = 1'b0;
    tick();
    push({16'h0001, 32'h0});
    check("rst_idle_rd_en", 80'(bus.srvf_rd_en), 80'h1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
